// File: rtl/prbs16_pkg.sv
// PRBS-16 shared definitions (x^16+x^14+x^13+x^11+1).
// Used by both the link generator and the receive checker.
package prbs16_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } prbs16_state_e;

    // Feedback taps at bits 15, 13, 12, 10.
    localparam logic [15:0] PRBS16_TAPS = 16'hB400;

    function automatic logic [15:0] prbs16_next(input logic [15:0] s);
        return {s[14:0], ^(s & PRBS16_TAPS)};
    endfunction

endpackage

// File: rtl/prbs16_checker.sv
// PRBS-16 receive checker: self-synchronising hunt/check/locked FSM
// with mismatch pulse and saturating locked-mode error counter.
module prbs16_checker
    import prbs16_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_p,
    input  logic        i_valid,
    input  logic        i_clr_cnt,
    output logic        o_lock,
    output logic        o_err,
    output logic [15:0] o_err_cnt,
    output logic [15:0] o_expect
);

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    prbs16_state_e state_q, state_d;
    logic [3:0]    run_q, run_d;
    logic [3:0]    run_inc;
    logic [15:0]   exp_d;
    logic          err_d;
    logic          match;

    assign match   = (i_p == o_expect);
    assign run_inc = run_q + 4'd1;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        exp_d   = o_expect;
        err_d   = 1'b0;
        if (i_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (i_p != 16'h0000) begin
                        exp_d   = prbs16_next(i_p);
                        run_d   = 4'd0;
                        state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (match) begin
                        exp_d = prbs16_next(o_expect);
                        if (run_inc == LOCK_N) begin
                            state_d = ST_LOCKED;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (i_p == 16'h0000) begin
                        state_d = ST_HUNT;
                        run_d   = 4'd0;
                    end else begin
                        exp_d = prbs16_next(i_p);
                        run_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    // Free-running prediction rides through isolated bit errors.
                    exp_d = prbs16_next(o_expect);
                    if (match) begin
                        run_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                        if (run_inc == UNLOCK_N) begin
                            state_d = ST_HUNT;
                            run_d   = 4'd0;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    run_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_HUNT;
            run_q    <= 4'd0;
            o_expect <= 16'h0000;
            o_lock   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            o_expect <= exp_d;
            o_lock   <= (state_d == ST_LOCKED);
            o_err    <= err_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_cnt <= 16'h0000;
        end else if (i_clr_cnt) begin
            o_err_cnt <= 16'h0000;
        end else if (err_d && (o_err_cnt != 16'hFFFF)) begin
            o_err_cnt <= o_err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_prbs16_checker.sv
// Randomised and directed bench for prbs16_checker against a
// behavioural model; second instance exercises counter saturation.
module tb_prbs16_checker;

    localparam int LOCK   = 4;
    localparam int UNLOCK = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] p = '0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic        o_lock, o_err;
    logic [15:0] o_err_cnt, o_expect;

    logic [15:0] s_p = '0;
    logic        s_valid = 1'b0;
    logic        s_clr = 1'b0;
    logic        s_lock, s_err;
    logic [15:0] s_err_cnt, s_expect;

    always #5 clk = ~clk;

    prbs16_checker #(.LOCK_CNT(LOCK), .UNLOCK_CNT(UNLOCK)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_p(p), .i_valid(valid),
        .i_clr_cnt(clr), .o_lock(o_lock), .o_err(o_err),
        .o_err_cnt(o_err_cnt), .o_expect(o_expect)
    );

    prbs16_checker #(.LOCK_CNT(1), .UNLOCK_CNT(15)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_p(s_p), .i_valid(s_valid),
        .i_clr_cnt(s_clr), .o_lock(s_lock), .o_err(s_err),
        .o_err_cnt(s_err_cnt), .o_expect(s_expect)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model of the checker
    bit          m_lock, m_sync, m_err;
    logic [15:0] m_exp, m_cnt;
    int          m_run;
    logic [15:0] gen, s_gen, w;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] nx(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] corrupt(input logic [15:0] v);
        logic [15:0] r;
        r = v ^ 16'h0010;
        if (r == 16'h0000) r = 16'h0020;
        return r;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_sync = 0; m_err = 0;
        m_exp = '0; m_cnt = '0; m_run = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit c);
        m_err = 0;
        if (v) begin
            if (m_lock) begin
                if (d == m_exp) m_run = 0;
                else begin m_err = 1; m_run++; end
                m_exp = nx(m_exp);
                if (m_run == UNLOCK) begin m_lock = 0; m_sync = 0; m_run = 0; end
            end else if (m_sync) begin
                if (d == m_exp) begin
                    m_run++;
                    m_exp = nx(m_exp);
                    if (m_run == LOCK) begin m_lock = 1; m_run = 0; end
                end else if (d == 16'h0000) begin
                    m_sync = 0; m_run = 0;
                end else begin
                    m_exp = nx(d); m_run = 0;
                end
            end else if (d != 16'h0000) begin
                m_exp = nx(d); m_sync = 1; m_run = 0;
            end
        end
        if (c) m_cnt = '0;
        else if (m_err && m_cnt != 16'hFFFF) m_cnt++;
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit c);
        @(negedge clk);
        valid = v; p = d; clr = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check("lock", 32'(o_lock), 32'(m_lock));
        check("err", 32'(o_err), 32'(m_err));
        check("err_cnt", 32'(o_err_cnt), 32'(m_cnt));
        check("expect", 32'(o_expect), 32'(m_exp));
    endtask

    task automatic send_good();
        step(1, gen, 0);
        gen = nx(gen);
    endtask

    task automatic sat_cycle(input bit v, input logic [15:0] d, input bit c);
        @(negedge clk);
        s_valid = v; s_p = d; s_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_lock", 32'(o_lock), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_cnt", 32'(o_err_cnt), 32'd0);
        check("rst_expect", 32'(o_expect), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Seed plus LOCK correct successors
        gen = 16'hACE1;
        for (int i = 0; i < LOCK + 1; i++) begin
            send_good();
            if (i == LOCK - 1) check("no_lock_yet", 32'(o_lock), 32'd0);
        end
        check("lock_5th", 32'(o_lock), 32'd1);
        check("expect_after_lock", 32'(o_expect), 32'(gen));

        // Isolated zero word while locked
        for (int i = 0; i < 3; i++) send_good();
        step(1, 16'h0000, 0);
        gen = nx(gen);
        check("iso_err", 32'(o_err), 32'd1);
        check("iso_cnt", 32'(o_err_cnt), 32'd1);
        check("iso_lock", 32'(o_lock), 32'd1);
        for (int i = 0; i < 4; i++) send_good();

        // Clear then UNLOCK consecutive bad words
        step(0, 16'h0000, 1);
        for (int i = 0; i < UNLOCK; i++) begin
            step(1, corrupt(gen), 0);
            gen = nx(gen);
            check("unlock_err", 32'(o_err), 32'd1);
        end
        check("unlock_cnt", 32'(o_err_cnt), 32'd3);
        check("unlock_lock", 32'(o_lock), 32'd0);

        // Zero in HUNT ignored, then seed with toggling valid
        w = o_expect;
        step(1, 16'h0000, 0);
        step(1, 16'h0000, 0);
        check("hunt_zero_lock", 32'(o_lock), 32'd0);
        gen = 16'hACE1;
        for (int i = 0; i < LOCK + 1; i++) begin
            send_good();
            step(0, 16'($urandom), 0);
        end
        check("toggle_lock", 32'(o_lock), 32'd1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit v, c;
            logic [15:0] d;
            v = ($urandom_range(3) != 0);
            c = ($urandom_range(31) == 0);
            if ($urandom_range(7) == 0) begin
                d = ($urandom_range(5) == 0) ? 16'h0000 : 16'($urandom);
                if (v) gen = (d != 0 && $urandom_range(1) == 1) ? nx(d) : nx(gen);
            end else begin
                d = gen;
                if (v) gen = nx(gen);
            end
            step(v, d, c);
        end

        // Async reset while locked with nonzero count
        gen = 16'hBEEF;
        for (int i = 0; i < LOCK + 1; i++) send_good();
        step(1, corrupt(gen), 0);
        gen = nx(gen);
        check("pre_rst_cnt", 32'(o_err_cnt != 0), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_lock", 32'(o_lock), 32'd0);
        check("arst_cnt", 32'(o_err_cnt), 32'd0);
        check("arst_expect", 32'(o_expect), 32'd0);
        check("arst_err", 32'(o_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gen = 16'h1234;
        for (int i = 0; i < LOCK + 1; i++) send_good();
        check("relock", 32'(o_lock), 32'd1);
        step(0, 16'h0000, 0);

        // Saturation on the long-unlock instance
        s_gen = 16'hACE1;
        sat_cycle(1, s_gen, 0);
        s_gen = nx(s_gen);
        sat_cycle(1, s_gen, 0);
        s_gen = nx(s_gen);
        check("sat_lock", 32'(s_lock), 32'd1);
        for (int b = 0; b < 4682; b++) begin
            for (int k = 0; k < 14; k++) begin
                sat_cycle(1, corrupt(s_gen), 0);
                s_gen = nx(s_gen);
            end
            sat_cycle(1, s_gen, 0);
            s_gen = nx(s_gen);
            if (b == 0) check("sat_cnt14", 32'(s_err_cnt), 32'd14);
        end
        check("sat_cnt_max", 32'(s_err_cnt), 32'hFFFF);
        check("sat_still_lock", 32'(s_lock), 32'd1);
        sat_cycle(1, corrupt(s_gen), 1);
        s_gen = nx(s_gen);
        check("clr_wins_err", 32'(s_err), 32'd1);
        check("clr_wins_cnt", 32'(s_err_cnt), 32'd0);
        sat_cycle(1, corrupt(s_gen), 0);
        s_gen = nx(s_gen);
        check("post_clr_cnt", 32'(s_err_cnt), 32'd1);
        sat_cycle(0, 16'h0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
